// File: rtl/hs32_decode_q.sv
// hs32_decode_q: HS32 instruction decoder feeding a DEPTH-entry queue of decoded entries.
// Optional feature macro HS32_DECODE_FAULT_EN: drop undefined opcodes and pulse fault.
module hs32_decode_q #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instd,
  input  logic        ackd,
  output logic        reqd,
  input  logic        flush,
  output logic        valid,
  input  logic        ready,
  output logic [2:0]  aluop,
  output logic [4:0]  shift,
  output logic [15:0] imm,
  output logic [3:0]  rd,
  output logic [3:0]  rm,
  output logic [3:0]  rn,
  output logic [1:0]  bank,
  output logic [15:0] ctlsig,
  output logic        fault
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    CLS_NONE  = 2'b00,
    CLS_REG   = 2'b01,
    CLS_LOAD  = 2'b10,
    CLS_STORE = 2'b11
  } cls_e;

  typedef enum logic [2:0] {
    SRC_NONE   = 3'b000,
    SRC_IMM    = 3'b001,
    SRC_RM     = 3'b010,
    SRC_RM_SH  = 3'b011,
    SRC_SH     = 3'b100,
    SRC_RM_IMM = 3'b101
  } src_e;

  typedef struct packed {
    logic [2:0]  aluop;
    logic [4:0]  shift;
    logic [15:0] imm;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  rn;
    logic [1:0]  bank;
    logic [15:0] ctlsig;
  } entry_t;

  logic [7:0] opcode;
  cls_e       dec_cls;
  src_e       dec_src;
  logic [2:0] dec_alu;
  logic       dec_defined;
  logic       sel_imm;
  logic       sel_sh;
  logic       sel_rm;
  entry_t     dec_entry;

  assign opcode = instd[31:24];

  // NOTE: every variable written in always_comb gets a default first so no path can infer a latch.
  always_comb begin
    dec_cls     = CLS_NONE;
    dec_src     = SRC_NONE;
    dec_alu     = 3'b000;
    dec_defined = 1'b1;
    case (opcode) inside
      8'h10: begin dec_cls = CLS_LOAD;  dec_src = SRC_RM_IMM; end
      8'h14: begin dec_cls = CLS_LOAD;  dec_src = SRC_RM_SH;  end
      8'h30: begin dec_cls = CLS_STORE; dec_src = SRC_RM_IMM; end
      8'h34: begin dec_cls = CLS_STORE; dec_src = SRC_RM_SH;  end
      8'h24: begin dec_cls = CLS_REG;   dec_src = SRC_IMM;    end
      8'h20: begin dec_cls = CLS_REG;   dec_src = SRC_SH;     end
      8'h21: begin dec_cls = CLS_REG;   dec_src = SRC_RM;     end
      [8'h40:8'h46]: begin
        dec_cls = CLS_REG;
        dec_src = SRC_RM_SH;
        dec_alu = instd[26:24];
      end
      [8'h48:8'h4E]: begin
        dec_cls = CLS_REG;
        dec_src = SRC_RM_IMM;
        dec_alu = instd[26:24];
      end
      default: dec_defined = 1'b0;
    endcase
  end

  // Fields a source does not consume are forced to zero so execute never sees stale bits.
  always_comb begin
    dec_entry = '0;
    sel_imm   = (dec_src == SRC_IMM) || (dec_src == SRC_RM_IMM);
    sel_sh    = (dec_src == SRC_RM_SH) || (dec_src == SRC_SH);
    sel_rm    = (dec_src == SRC_RM) || (dec_src == SRC_RM_SH) || (dec_src == SRC_RM_IMM);
    if (dec_defined) begin
      dec_entry.aluop          = dec_alu;
      dec_entry.rd             = instd[23:20];
      dec_entry.bank           = instd[8:7];
      dec_entry.ctlsig[15:14]  = dec_cls;
      dec_entry.ctlsig[13:11]  = dec_src;
      dec_entry.ctlsig[0]      = (dec_alu == 3'b001) || (dec_alu == 3'b011);
      if (sel_rm) begin
        dec_entry.rm = instd[19:16];
      end
      if (sel_imm) begin
        dec_entry.imm = instd[15:0];
      end
      if (sel_sh) begin
        dec_entry.shift       = instd[15:11];
        dec_entry.rn          = instd[15:12];
        dec_entry.ctlsig[2:1] = instd[10:9];
      end
    end
  end

  logic          drop_undef;
  logic          push;
  logic          wr_en;
  logic          pop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  entry_t        mem [DEPTH];
  entry_t        head;

`ifdef HS32_DECODE_FAULT_EN
  assign drop_undef = !dec_defined;
`else
  assign drop_undef = 1'b0;
`endif

  assign push  = ackd && reqd;
  assign wr_en = push && !drop_undef;
  assign pop   = valid && ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the entry array has no reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      mem[wr_ptr] <= dec_entry;
    end
  end

`ifdef HS32_DECODE_FAULT_EN
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      fault <= 1'b0;
    end else begin
      fault <= push && !dec_defined;
    end
  end
`else
  assign fault = 1'b0;
`endif

  assign head  = mem[rd_ptr];
  assign valid = (count != '0);
  assign reqd  = !reset && (count != CW'(DEPTH));

  assign {aluop, shift, imm, rd, rm, rn, bank, ctlsig} = valid ? head : '0;

endmodule

// File: tb/tb_hs32_decode_q.sv
// Randomised bench for hs32_decode_q: DEPTH=2 and DEPTH=4 instances share stimulus and are
// compared every cycle against a queue-level reference model.
module tb_hs32_decode_q;

  typedef struct packed {
    logic [2:0]  aluop;
    logic [4:0]  shift;
    logic [15:0] imm;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  rn;
    logic [1:0]  bank;
    logic [15:0] ctlsig;
  } ent_t;

`ifdef HS32_DECODE_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        ackd;
  logic        ready;
  logic [31:0] instd;

  logic        q_reqd  [2];
  logic        q_valid [2];
  logic        q_fault [2];
  logic [2:0]  q_aluop [2];
  logic [4:0]  q_shift [2];
  logic [15:0] q_imm   [2];
  logic [3:0]  q_rd    [2];
  logic [3:0]  q_rm    [2];
  logic [3:0]  q_rn    [2];
  logic [1:0]  q_bank  [2];
  logic [15:0] q_ctl   [2];

  always #5 clk = ~clk;

  hs32_decode_q #(.DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .instd(instd), .ackd(ackd), .reqd(q_reqd[0]),
    .flush(flush), .valid(q_valid[0]), .ready(ready), .aluop(q_aluop[0]),
    .shift(q_shift[0]), .imm(q_imm[0]), .rd(q_rd[0]), .rm(q_rm[0]), .rn(q_rn[0]),
    .bank(q_bank[0]), .ctlsig(q_ctl[0]), .fault(q_fault[0])
  );

  hs32_decode_q #(.DEPTH(4)) u_d4 (
    .clk(clk), .reset(reset), .instd(instd), .ackd(ackd), .reqd(q_reqd[1]),
    .flush(flush), .valid(q_valid[1]), .ready(ready), .aluop(q_aluop[1]),
    .shift(q_shift[1]), .imm(q_imm[1]), .rd(q_rd[1]), .rm(q_rm[1]), .rn(q_rn[1]),
    .bank(q_bank[1]), .ctlsig(q_ctl[1]), .fault(q_fault[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decode built directly from the opcode table and field rules.
  function automatic bit ref_defined(logic [7:0] op);
    return (op inside {8'h10, 8'h14, 8'h30, 8'h34, 8'h24, 8'h20, 8'h21}) ||
           (op >= 8'h40 && op <= 8'h46) || (op >= 8'h48 && op <= 8'h4E);
  endfunction

  function automatic ent_t ref_decode(logic [31:0] i);
    ent_t       e;
    logic [7:0] op;
    int         cls;
    int         src;
    int         alu;
    e   = '0;
    op  = i[31:24];
    cls = 0;
    src = 0;
    alu = 0;
    if (!ref_defined(op)) return e;
    if (op == 8'h10 || op == 8'h30) begin
      cls = (op == 8'h10) ? 2 : 3;
      src = 5;
    end else if (op == 8'h14 || op == 8'h34) begin
      cls = (op == 8'h14) ? 2 : 3;
      src = 3;
    end else if (op == 8'h24) begin
      cls = 1; src = 1;
    end else if (op == 8'h20) begin
      cls = 1; src = 4;
    end else if (op == 8'h21) begin
      cls = 1; src = 2;
    end else if (op <= 8'h46) begin
      cls = 1; src = 3; alu = int'(op) - 'h40;
    end else begin
      cls = 1; src = 5; alu = int'(op) - 'h48;
    end
    e.aluop = 3'(alu);
    e.rd    = i[23:20];
    e.bank  = i[8:7];
    if (src != 1 && src != 4) e.rm = i[19:16];
    if (src == 1 || src == 5) e.imm = i[15:0];
    if (src == 3 || src == 4) begin
      e.shift = i[15:11];
      e.rn    = i[15:12];
    end
    e.ctlsig = {2'(cls), 3'(src), 8'h00,
                (src == 3 || src == 4) ? i[10:9] : 2'b00,
                (alu == 1 || alu == 3) ? 1'b1 : 1'b0};
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    int         s;
    logic [7:0] op;
    s = $urandom_range(0, 23);
    case (s)
      0: op = 8'h10;
      1: op = 8'h14;
      2: op = 8'h30;
      3: op = 8'h34;
      4: op = 8'h24;
      5: op = 8'h20;
      6: op = 8'h21;
      default: begin
        if (s <= 13)      op = 8'(8'h40 + s - 7);
        else if (s <= 20) op = 8'(8'h48 + s - 14);
        else              op = 8'($urandom);
      end
    endcase
    return {op, 24'($urandom)};
  endfunction

  // Model: per-instance circular list of expected entries plus the expected fault flag.
  ent_t mbuf   [2][8];
  int   mhead  [2];
  int   mcnt   [2];
  bit   mfault [2];

  function automatic int depth_of(int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic ent_t observed(int k);
    return {q_aluop[k], q_shift[k], q_imm[k], q_rd[k], q_rm[k], q_rn[k], q_bank[k], q_ctl[k]};
  endfunction

  // Compare both instances with the model, advance the model on the current inputs,
  // then let one clock edge pass. Returns on the following falling edge.
  task automatic tick();
    #1;
    for (int k = 0; k < 2; k++) begin
      int   d;
      ent_t exp_e;
      bit   acc;
      d     = depth_of(k);
      exp_e = (mcnt[k] != 0) ? mbuf[k][mhead[k]] : '0;
      check($sformatf("d%0d.valid", d), q_valid[k], mcnt[k] != 0);
      check($sformatf("d%0d.reqd", d), q_reqd[k], !reset && mcnt[k] != d);
      check($sformatf("d%0d.fault", d), q_fault[k], mfault[k]);
      check($sformatf("d%0d.entry", d), observed(k), exp_e);
      acc = ackd && !reset && (mcnt[k] != d);
      if (reset || flush) begin
        mcnt[k]   = 0;
        mhead[k]  = 0;
        mfault[k] = 1'b0;
      end else begin
        if (mcnt[k] != 0 && ready) begin
          mhead[k] = (mhead[k] + 1) % d;
          mcnt[k]--;
        end
        mfault[k] = acc && FAULT_EN && !ref_defined(instd[31:24]);
        if (acc && !(FAULT_EN && !ref_defined(instd[31:24]))) begin
          mbuf[k][(mhead[k] + mcnt[k]) % d] = ref_decode(instd);
          mcnt[k]++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mhead[k]  = 0;
      mcnt[k]   = 0;
      mfault[k] = 1'b0;
    end
    reset = 1'b1;
    flush = 1'b0;
    ackd  = 1'b0;
    ready = 1'b0;
    instd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state: nothing valid, reqd held low while reset is asserted.
    tick();
    check("rst.valid", q_valid[0], 1'b0);
    check("rst.reqd", q_reqd[0], 1'b0);
    check("rst.ctlsig", q_ctl[0], 16'h0000);
    reset = 1'b0;
    #1;
    check("rel.reqd", q_reqd[0], 1'b1);
    tick();

    // ADDC with shifted register source.
    instd = 32'h4132_1000;
    ackd  = 1'b1;
    ready = 1'b1;
    tick();
    ackd = 1'b0;
    check("addc.valid", q_valid[0], 1'b1);
    check("addc.aluop", q_aluop[0], 3'b001);
    check("addc.rd", q_rd[0], 4'd3);
    check("addc.rm", q_rm[0], 4'd2);
    check("addc.rn", q_rn[0], 4'd1);
    check("addc.ctlsig", q_ctl[0], 16'h5801);
    check("addc.imm", q_imm[0], 16'h0000);
    tick();

    // LDR with immediate offset.
    instd = 32'h1045_0010;
    ackd  = 1'b1;
    tick();
    ackd = 1'b0;
    check("ldr.ctlsig", q_ctl[0], 16'hA800);
    check("ldr.imm", q_imm[0], 16'h0010);
    check("ldr.rn", q_rn[0], 4'd0);
    check("ldr.shift", q_shift[0], 5'd0);
    check("ldr.rm", q_rm[0], 4'd5);
    tick();

    // Back-pressure on DEPTH=2: third instruction held until space frees, order kept.
    ready = 1'b0;
    ackd  = 1'b1;
    instd = 32'h4010_0000;
    tick();
    instd = 32'h4020_0000;
    tick();
    check("full.reqd", q_reqd[0], 1'b0);
    instd = 32'h4030_0000;
    tick();
    check("held.rd", q_rd[0], 4'd1);
    ready = 1'b1;
    #1;
    check("drain0.rd", q_rd[0], 4'd1);
    tick();
    check("drain1.rd", q_rd[0], 4'd2);
    tick();
    check("drain2.rd", q_rd[0], 4'd3);
    ackd = 1'b0;
    tick();
    check("drained.valid", q_valid[0], 1'b0);
    repeat (6) tick();

    // Flush a full buffer while a transfer is offered.
    ready = 1'b0;
    ackd  = 1'b1;
    instd = 32'h4010_0000;
    tick();
    instd = 32'h4020_0000;
    tick();
    flush = 1'b1;
    instd = 32'h40F0_0000;
    tick();
    flush = 1'b0;
    ackd  = 1'b0;
    check("flush.valid", q_valid[0], 1'b0);
    check("flush.reqd", q_reqd[0], 1'b1);
    check("flush.valid4", q_valid[1], 1'b0);
    tick();
    check("flush.absent", q_valid[0], 1'b0);

    // Undefined opcode.
    instd = 32'hFF00_0000;
    ackd  = 1'b1;
    tick();
    ackd = 1'b0;
    check("undef.fault", q_fault[0], FAULT_EN);
    check("undef.valid", q_valid[0], !FAULT_EN);
    check("undef.ctlsig", q_ctl[0], 16'h0000);
    tick();
    check("undef.pulse", q_fault[0], 1'b0);
    ready = 1'b1;
    tick();

    // Undefined opcode during flush: dropped, no fault.
    flush = 1'b1;
    ackd  = 1'b1;
    tick();
    flush = 1'b0;
    ackd  = 1'b0;
    check("flushundef.fault", q_fault[0], 1'b0);
    tick();

    // Reset mid-operation with a transfer offered.
    ready = 1'b0;
    ackd  = 1'b1;
    instd = 32'h2400_1234;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ackd  = 1'b0;
    check("midrst.valid", q_valid[0], 1'b0);
    tick();

    // Random traffic: streaming phase first, then with occasional flush and reset.
    for (int c = 0; c < 500; c++) begin
      instd = rand_instr();
      ackd  = ($urandom % 4) != 0;
      ready = ($urandom % 2) != 0;
      flush = (c >= 80) && (($urandom % 40) == 0);
      reset = (c >= 80) && (($urandom % 150) == 0);
      tick();
    end
    reset = 1'b0;
    flush = 1'b0;
    ackd  = 1'b0;
    ready = 1'b1;
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hs32_decode_q.md
HS32_DECODE_Q -- requirements
Module: hs32_decode_q

Interface
REQ-001 SHALL have parameter DEPTH, default 2, decoded-entry buffer depth (legal 2, 4, 8; pointers wrap modulo DEPTH).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port instd  in  32  instruction from fetch.
REQ-005 SHALL have port ackd  in  1  instd valid.
REQ-006 SHALL have port reqd  out  1  decoder can accept; transfer when ackd && reqd.
REQ-007 SHALL have port flush  in  1  discard all buffered entries.
REQ-008 SHALL have port valid  out  1  head entry valid to execute.
REQ-009 SHALL have port ready  in  1  execute consumes head when valid && ready.
REQ-010 SHALL have ports aluop out 3, shift out 5, imm out 16, rd/rm/rn out 4 each, bank out 2, ctlsig out 16; all from head entry.
REQ-011 SHALL have port fault  out  1  undefined-opcode pulse.

Function
REQ-012 Opcode SHALL be instd[31:24]; fields: rd=[23:20], rm=[19:16], rn=[15:12], shift=[15:11], shiftdir=[10:9], bank=[8:7], imm=[15:0].
REQ-013 ctlsig SHALL be: [15:14] class (00 none, 01 reg-write, 10 load, 11 store); [13:11] source (001 imm, 010 Rm, 011 Rm+sh(Rn), 100 sh(Rn), 101 Rm+imm); [10:3] zero; [2:1] shiftdir for sources 011/100 else 0; [0] carry-in.
REQ-014 Table SHALL be: 0x10 LDR class10/src101; 0x14 LDR class10/src011; 0x30 STR class11/src101; 0x34 STR class11/src011; 0x24 MOV-imm class01/src001; 0x20 MOV-sh class01/src100; 0x21 MOV-reg class01/src010.
REQ-015 Opcodes 0x40-0x46 SHALL be class01/src011 and 0x48-0x4E class01/src101, aluop=instd[26:24] (000 ADD, 001 ADDC, 010 SUB, 011 SUBC, 100 AND, 101 OR, 110 XOR), ctlsig[0]=1 for ADDC/SUBC only.
REQ-016 Loads, stores and moves SHALL use aluop=000, ctlsig[0]=0.
REQ-017 Fields unused by the selected source SHALL be zero (imm only for 001/101; shift, rn only for 011/100; rm zero for 001/100); rd, bank always passed.
REQ-018 Accepted instruction SHALL be decoded and written to the buffer tail at the accepting edge; if buffer was empty, valid=1 on the next cycle (latency 1).
REQ-019 reqd SHALL equal (count != DEPTH); no pass-through when full.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; entries leave in acceptance order.
REQ-021 Outputs SHALL hold stable while valid && !ready; all decoded outputs SHALL be zero when valid=0.
REQ-022 flush SHALL clear count and pointers at the edge, taking priority over push and pop; an instruction transferred in the flush cycle SHALL be dropped and fault suppressed.

Reset
REQ-023 On reset: count, pointers, valid, fault, all decoded outputs = 0; reqd = 0 while reset asserted, 1 the cycle after release.
REQ-024 Reset mid-operation SHALL discard all entries and any in-flight transfer.

Configuration
REQ-025 With HS32_DECODE_FAULT_EN defined, an accepted undefined opcode SHALL NOT be enqueued and fault SHALL be 1 for exactly the following cycle.
REQ-026 Without HS32_DECODE_FAULT_EN, undefined opcodes SHALL be enqueued as NOP (ctlsig=0, all fields 0) and fault tied to 0.

Verification
REQ-027 Reset, then instd=0x41321000 with ackd=1, ready=1 -> next cycle valid=1, aluop=001, rd=3, rm=2, rn=1, ctlsig=0x5800+shiftdir bits, ctlsig[0]=1.
REQ-028 DEPTH=2, ready=0, three back-to-back ackd -> reqd=0 after two accepts; third held; ready=1 then drains in order.
REQ-029 instd=0x10450010 (LDR imm) -> ctlsig=0xA800, imm=0x0010, rn=0, shift=0.
REQ-030 Full buffer, flush=1 with ackd=1 -> next cycle valid=0, count 0, reqd=1, flushed instruction absent.
REQ-031 instd=0xFF000000 -> with HS32_DECODE_FAULT_EN fault=1 one cycle, valid stays 0; without, valid=1, ctlsig=0, fault=0.
REQ-032 DEPTH=4, continuous push/pop with ready toggling for 20 instructions -> no loss, no duplication, pointer wrap correct.
